// File: rtl/jtag_dbg_cmd_bridge.sv
// System-clock side of the debug JTAG path: strobe synchronisation, command capture and action pulses.
// Optional acknowledge timeout is enabled by defining DBG_CMD_TIMEOUT_EN.
module jtag_dbg_cmd_bridge #(
  parameter int IR_W        = 2,
  parameter int SR_W        = 38,
  parameter int ACT_BIT     = 34,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vs_udr,
  input  logic                 vs_uir,
  input  logic [IR_W-1:0]      ir_in,
  input  logic [SR_W-1:0]      sr,
  input  logic                 cmd_ready,
  input  logic                 clr_status,
  output logic [SR_W-1:0]      jdo,
  output logic [IR_W-1:0]      cmd_code,
  output logic                 cmd_valid,
  output logic [2**IR_W-1:0]   take_action,
  output logic [2**IR_W-1:0]   take_no_action,
  output logic                 ir_update,
  output logic [7:0]           dropped_cnt,
  output logic                 err_timeout
);

  // state | meaning
  // IDLE  | no command pending, waiting for an update-DR rise
  // ISSUE | command captured in jdo/cmd_code, waiting for cmd_ready
  typedef enum logic [0:0] {IDLE, ISSUE} state_t;

  localparam int NCMD = 2**IR_W;

  if (SYNC_STAGES < 2 || ACT_BIT >= SR_W || ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_param_check
    $error("jtag_dbg_cmd_bridge: illegal parameter combination");
  end

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] udr_sync, uir_sync, fill;
  logic                   udr_prev, uir_prev;
  logic                   udr_armed, uir_armed;
  logic                   udr_rise, uir_rise;
  logic                   capture, complete, drop;
  logic [NCMD-1:0]        cmd_onehot;

  // fill marks when the synchroniser holds real samples rather than reset zeros,
  // so a strobe held high across reset release never arms.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      udr_sync  <= '0;
      uir_sync  <= '0;
      fill      <= '0;
      udr_prev  <= 1'b0;
      uir_prev  <= 1'b0;
      udr_armed <= 1'b0;
      uir_armed <= 1'b0;
    end else begin
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      fill     <= {fill[SYNC_STAGES-2:0], 1'b1};
      udr_prev <= udr_sync[SYNC_STAGES-1];
      uir_prev <= uir_sync[SYNC_STAGES-1];
      if (fill[SYNC_STAGES-1] && !udr_sync[SYNC_STAGES-1]) udr_armed <= 1'b1;
      if (fill[SYNC_STAGES-1] && !uir_sync[SYNC_STAGES-1]) uir_armed <= 1'b1;
    end
  end

  assign udr_rise   = udr_armed & udr_sync[SYNC_STAGES-1] & ~udr_prev;
  assign uir_rise   = uir_armed & uir_sync[SYNC_STAGES-1] & ~uir_prev;
  assign cmd_valid  = (state == ISSUE);
  assign cmd_onehot = NCMD'(1) << cmd_code;

`ifdef DBG_CMD_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       timeout;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    complete  = 1'b0;
    drop      = 1'b0;
`ifdef DBG_CMD_TIMEOUT_EN
    timeout   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (udr_rise) begin
          capture   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          complete = 1'b1;
          if (udr_rise) capture = 1'b1;
          else          state_nxt = IDLE;
        end else begin
          drop = udr_rise;
`ifdef DBG_CMD_TIMEOUT_EN
          if (tmo_cnt == 8'd0) begin
            timeout   = 1'b1;
            state_nxt = IDLE;
          end
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pulses are decoded from the held command, so a same-edge recapture
  // still fires the pulse of the command being completed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jdo            <= '0;
      cmd_code       <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      ir_update      <= 1'b0;
      dropped_cnt    <= 8'd0;
    end else begin
      if (capture) begin
        jdo      <= sr;
        cmd_code <= ir_in;
      end
      take_action    <= (complete &&  jdo[ACT_BIT]) ? cmd_onehot : '0;
      take_no_action <= (complete && !jdo[ACT_BIT]) ? cmd_onehot : '0;
      ir_update      <= uir_rise;
      if (clr_status)                         dropped_cnt <= 8'd0;
      else if (drop && dropped_cnt != 8'hFF)  dropped_cnt <= dropped_cnt + 8'd1;
    end
  end

`ifdef DBG_CMD_TIMEOUT_EN
  // Down-counter loaded on every capture; terminal count 0 ends the wait.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt     <= 8'd0;
      err_timeout <= 1'b0;
    end else begin
      if (capture)
        tmo_cnt <= 8'(ACK_TIMEOUT - 1);
      else if (state == ISSUE && !cmd_ready && tmo_cnt != 8'd0)
        tmo_cnt <= tmo_cnt - 8'd1;
      if (clr_status)   err_timeout <= 1'b0;
      else if (timeout) err_timeout <= 1'b1;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_jtag_dbg_cmd_bridge.sv
// Directed bench for jtag_dbg_cmd_bridge; timeout section follows DBG_CMD_TIMEOUT_EN.
module tb_jtag_dbg_cmd_bridge;

  logic        clk, reset, vs_udr, vs_uir, cmd_ready, clr_status;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic [37:0] jdo;
  logic [1:0]  cmd_code;
  logic        cmd_valid, ir_update, err_timeout;
  logic [3:0]  take_action, take_no_action;
  logic [7:0]  dropped_cnt;

  int n_chk = 0, n_fail = 0;
  int act_cycles = 0, nact_cycles = 0, onehot_bad = 0;
  int exp_act = 0, exp_nact = 0;

  localparam logic [37:0] SR_A1 = 38'h04_0000_1234;
  localparam logic [37:0] SR_N2 = 38'h00_0000_00AB;
  localparam logic [37:0] SR_A  = 38'h04_DEAD_0001;
  localparam logic [37:0] SR_B  = 38'h01_2345_6789;
  localparam logic [37:0] SR_C  = 38'h00_0000_5555;
  localparam logic [37:0] SR_D  = 38'h04_0000_0003;
  localparam logic [37:0] SR_E  = 38'h04_1111_2222;

  jtag_dbg_cmd_bridge #(
    .IR_W(2), .SR_W(38), .ACT_BIT(34), .SYNC_STAGES(2), .ACK_TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready), .clr_status(clr_status),
    .jdo(jdo), .cmd_code(cmd_code), .cmd_valid(cmd_valid),
    .take_action(take_action), .take_no_action(take_no_action),
    .ir_update(ir_update), .dropped_cnt(dropped_cnt), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (take_action != 4'd0)    act_cycles++;
    if (take_no_action != 4'd0) nact_cycles++;
    if (!$onehot0({take_action, take_no_action})) onehot_bad++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise vs_udr and return just after the edge where the rise is acted on.
  task automatic udr_raise(input logic [1:0] ir, input logic [37:0] data);
    ir_in  = ir;
    sr     = data;
    vs_udr = 1'b1;
    tick(3);
    vs_udr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; vs_udr = 1'b1; vs_uir = 1'b0; cmd_ready = 1'b0; clr_status = 1'b0;
    ir_in = 2'd0; sr = '0;
    tick(2);
    chk("rst_jdo", 64'(jdo), 64'd0);
    chk("rst_valid", 64'(cmd_valid), 64'd0);
    chk("rst_pulses", 64'({take_action, take_no_action, ir_update}), 64'd0);
    chk("rst_status", 64'({dropped_cnt, err_timeout}), 64'd0);

    // vs_udr high across reset release must not produce a command
    reset = 1'b0;
    tick(10);
    chk("arm_no_valid", 64'(cmd_valid), 64'd0);
    chk("arm_no_drop", 64'(dropped_cnt), 64'd0);
    vs_udr = 1'b0;
    tick(4);

    // action command, latency SYNC_STAGES+1
    cmd_ready = 1'b1; ir_in = 2'b01; sr = SR_A1; vs_udr = 1'b1;
    tick(2);
    chk("lat_e2_valid", 64'(cmd_valid), 64'd0);
    tick(1);
    vs_udr = 1'b0;
    chk("lat_e3_valid", 64'(cmd_valid), 64'd1);
    chk("cap1_jdo", 64'(jdo), 64'(SR_A1));
    chk("cap1_code", 64'(cmd_code), 64'd1);
    tick(1);
    chk("act1_pulse", 64'(take_action), 64'b0010);
    chk("act1_nact", 64'(take_no_action), 64'd0);
    chk("act1_valid", 64'(cmd_valid), 64'd0);
    exp_act++;
    tick(1);
    chk("act1_gone", 64'(take_action), 64'd0);
    tick(2);

    // no-action command
    udr_raise(2'b11, SR_N2);
    tick(1);
    chk("nact2_pulse", 64'(take_no_action), 64'b1000);
    chk("nact2_act", 64'(take_action), 64'd0);
    exp_nact++;
    tick(1);
    chk("nact2_gone", 64'(take_no_action), 64'd0);
    tick(2);

    // updates while busy are dropped, counter saturates, clr_status clears
    cmd_ready = 1'b0;
    udr_raise(2'b10, SR_A);
    tick(3);
    chk("busy_valid", 64'(cmd_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      udr_raise(2'(i), SR_B);
      tick(3);
    end
    chk("drop3_cnt", 64'(dropped_cnt), 64'd3);
    chk("drop3_jdo", 64'(jdo), 64'(SR_A));
    chk("drop3_code", 64'(cmd_code), 64'd2);
    for (int i = 0; i < 253; i++) begin
      udr_raise(2'b00, SR_B);
      tick(2);
    end
    chk("drop_sat", 64'(dropped_cnt), 64'd255);
    clr_status = 1'b1;
    tick(1);
    clr_status = 1'b0;
    chk("drop_clr", 64'(dropped_cnt), 64'd0);

    // cmd_ready on the same edge as a new capture
    ir_in = 2'b01; sr = SR_C; vs_udr = 1'b1;
    tick(2);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0; vs_udr = 1'b0;
    chk("same_pulse", 64'(take_action), 64'b0100);
    chk("same_valid", 64'(cmd_valid), 64'd1);
    chk("same_jdo", 64'(jdo), 64'(SR_C));
    chk("same_code", 64'(cmd_code), 64'd1);
    chk("same_nodrop", 64'(dropped_cnt), 64'd0);
    exp_act++;
    tick(1);
    chk("same_gone", 64'(take_action), 64'd0);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    chk("same_fin_pulse", 64'(take_no_action), 64'b0010);
    chk("same_fin_valid", 64'(cmd_valid), 64'd0);
    exp_nact++;
    tick(2);

    // ir_update pulse
    vs_uir = 1'b1;
    tick(2);
    chk("uir_e2", 64'(ir_update), 64'd0);
    tick(1);
    chk("uir_e3", 64'(ir_update), 64'd1);
    tick(1);
    vs_uir = 1'b0;
    chk("uir_e4", 64'(ir_update), 64'd0);
    chk("uir_no_cmd", 64'(cmd_valid), 64'd0);
    tick(3);

    // acknowledge timeout (or indefinite hold without the feature)
    udr_raise(2'b11, SR_D);
`ifdef DBG_CMD_TIMEOUT_EN
    tick(7);
    chk("tmo_e7_valid", 64'(cmd_valid), 64'd1);
    chk("tmo_e7_err", 64'(err_timeout), 64'd0);
    tick(1);
    chk("tmo_valid", 64'(cmd_valid), 64'd0);
    chk("tmo_err", 64'(err_timeout), 64'd1);
    chk("tmo_nopulse", 64'({take_action, take_no_action}), 64'd0);
    clr_status = 1'b1;
    tick(1);
    clr_status = 1'b0;
    chk("tmo_clr", 64'(err_timeout), 64'd0);
`else
    tick(20);
    chk("hold_valid", 64'(cmd_valid), 64'd1);
    chk("hold_err", 64'(err_timeout), 64'd0);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    chk("hold_pulse", 64'(take_action), 64'b1000);
    exp_act++;
`endif
    tick(3);

    // reset while a command is pending abandons it
    udr_raise(2'b00, SR_E);
    chk("rst_mid_valid0", 64'(cmd_valid), 64'd1);
    reset = 1'b1; cmd_ready = 1'b1;
    tick(1);
    chk("rst_mid_valid", 64'(cmd_valid), 64'd0);
    chk("rst_mid_jdo", 64'(jdo), 64'd0);
    reset = 1'b0;
    tick(1);
    cmd_ready = 1'b0;
    chk("rst_mid_nopulse", 64'({take_action, take_no_action}), 64'd0);
    tick(2);

    #1;
    chk("tot_act_cycles", 64'(act_cycles), 64'(exp_act));
    chk("tot_nact_cycles", 64'(nact_cycles), 64'(exp_nact));
    chk("onehot", 64'(onehot_bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
